// File: rtl/lfsr8_pkg.sv
// lfsr8_pkg: shared state codes, tap mask and next-value function for the lfsr8 generator and checker
package lfsr8_pkg;
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] TAP_MASK = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & TAP_MASK)};
    endfunction
endpackage

// File: rtl/lfsr8_checker.sv
// lfsr8_checker: locks onto an 8-bit Fibonacci LFSR stream and counts mismatches once locked
module lfsr8_checker
    import lfsr8_pkg::*;
#(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] data_in,
    input  logic       clr_cnt,
    output logic       locked,
    output logic       err_pulse,
    output logic [7:0] err_count,
    output logic [1:0] state
);
    state_t     st, st_n;
    logic [7:0] exp_q, exp_n, cnt_n;
    logic [3:0] match_cnt, match_n, miss_cnt, miss_n;
    logic       hit, cnt_err;

    assign hit   = en && data_in != 8'h00 && data_in == exp_q;
    assign state = st;
    assign cnt_n = clr_cnt ? {7'd0, cnt_err} :
                   (cnt_err && err_count != 8'hFF) ? err_count + 8'd1 : err_count;

    always_comb begin
        st_n    = st;
        exp_n   = exp_q;
        match_n = match_cnt;
        miss_n  = miss_cnt;
        cnt_err = 1'b0;
        case (st)
            HUNT: if (en && data_in != 8'h00) begin
                st_n    = VERIFY;
                exp_n   = lfsr_next(data_in);
                match_n = 4'd0;
            end
            VERIFY: if (hit) begin
                match_n = match_cnt + 4'd1;
                exp_n   = lfsr_next(data_in);
                if (match_n == 4'(LOCK_COUNT)) begin
                    st_n   = LOCKED;
                    miss_n = 4'd0;
                end
            end else if (en) begin
                // A failed verify is treated as a fresh HUNT sample
                st_n    = data_in != 8'h00 ? VERIFY : HUNT;
                exp_n   = data_in != 8'h00 ? lfsr_next(data_in) : exp_q;
                match_n = 4'd0;
            end
            LOCKED: if (en) begin
                exp_n   = lfsr_next(exp_q);
                cnt_err = !hit;
                miss_n  = hit ? 4'd0 : miss_cnt + 4'd1;
                if (!hit && miss_n == 4'(UNLOCK_COUNT))
                    st_n = HUNT;
            end
            default: st_n = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= HUNT;
            exp_q     <= 8'h00;
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= 8'h00;
        end else begin
            st        <= st_n;
            exp_q     <= exp_n;
            match_cnt <= match_n;
            miss_cnt  <= miss_n;
            locked    <= st_n == LOCKED;
            err_pulse <= cnt_err;
            err_count <= cnt_n;
        end
    end
endmodule

// File: tb/tb_lfsr8_checker.sv
// tb_lfsr8_checker: directed stimulus against a behavioural lock/flywheel model, checked every cycle
module tb_lfsr8_checker;
    localparam int LOCK = 4;
    localparam int UNLOCK = 3;

    logic       clk = 0, reset = 1, en = 0, clr_cnt = 0;
    logic [7:0] data_in = 0;
    logic       locked, err_pulse;
    logic [7:0] err_count;
    logic [1:0] state;

    int checks = 0, errors = 0;
    int m_mode = 0, m_run = 0, m_miss = 0, m_err = 0;
    logic [7:0] m_exp = 0;
    logic m_pulse = 0;

    lfsr8_checker #(.LOCK_COUNT(LOCK), .UNLOCK_COUNT(UNLOCK)) dut (
        .clk(clk), .reset(reset), .en(en), .data_in(data_in), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] nxt(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // Model: mode 0 hunting, 1 verifying, 2 locked
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_exp = 0; m_run = 0; m_miss = 0; m_err = 0; m_pulse = 0;
        end else begin
            logic good, bad;
            bad = 0;
            if (en) begin
                good = data_in != 0 && data_in == m_exp;
                if (m_mode == 2) begin
                    m_exp = nxt(m_exp);
                    if (good) m_miss = 0;
                    else begin
                        bad = 1;
                        m_miss++;
                        if (m_miss == UNLOCK) m_mode = 0;
                    end
                end else if (m_mode == 1 && good) begin
                    m_run++;
                    m_exp = nxt(data_in);
                    if (m_run == LOCK) begin m_mode = 2; m_miss = 0; end
                end else if (data_in != 0) begin
                    m_mode = 1; m_run = 0; m_exp = nxt(data_in);
                end else m_mode = 0;
            end
            m_pulse = bad;
            m_err = clr_cnt ? int'(bad) : (bad ? (m_err >= 255 ? 255 : m_err + 1) : m_err);
        end
    end

    always @(negedge clk) begin
        chk("state", state, m_mode);
        chk("locked", locked, m_mode == 2);
        chk("err_pulse", err_pulse, m_pulse);
        chk("err_count", err_count, m_err);
    end

    task automatic strobe(input logic [7:0] d, input logic c = 0);
        @(negedge clk); #1 en = 1; data_in = d; clr_cnt = c;
        @(negedge clk); #1 en = 0; clr_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1 reset = 1;
        @(negedge clk); #1 reset = 0;
    endtask

    task automatic acquire();
        strobe(8'h01);
        chk("verify_after_01", state, 1);
        strobe(8'h02); strobe(8'h04); strobe(8'h08); strobe(8'h11);
        chk("locked_after_11", locked, 1);
        chk("exp_after_11", m_exp, 8'h23);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #12;
        chk("reset_locked", locked, 0);
        chk("reset_err_count", err_count, 0);
        chk("reset_state", state, 0);
        @(negedge clk); #1 reset = 0;

        // zero samples hold HUNT; a bad value in VERIFY re-seeds
        strobe(8'h00); chk("zero_hunt1", state, 0);
        strobe(8'h00); chk("zero_hunt2", state, 0);
        strobe(8'h01); strobe(8'h02);
        strobe(8'h07);
        chk("reseed_state", state, 1);
        chk("reseed_exp", m_exp, 8'h0E);
        strobe(8'h0E);
        chk("reseed_follow", state, 1);
        chk("reseed_no_err", err_count, 0);

        // lock and a single flywheel error
        do_reset();
        acquire();
        chk("lock_err_count", err_count, 0);
        strobe(8'h55);
        chk("single_err_count", err_count, 1);
        chk("single_locked", locked, 1);
        strobe(8'h47);
        chk("single_recover_count", err_count, 1);
        chk("single_recover_locked", locked, 1);

        // loss of lock
        do_reset();
        acquire();
        repeat (3) strobe(8'hAA);
        chk("loss_err_count", err_count, 3);
        chk("loss_locked", locked, 0);
        chk("loss_state", state, 0);

        // asynchronous reset while locked
        acquire();
        @(posedge clk); #3 reset = 1;
        #1;
        chk("async_locked", locked, 0);
        chk("async_err_count", err_count, 0);
        @(negedge clk); #1 reset = 0;

        // saturation then clear with and without a coincident mismatch
        acquire();
        for (int i = 0; i < 300; i++) begin
            strobe(~m_exp);
            if (i % 2 == 1) strobe(m_exp);
        end
        chk("sat_count", err_count, 8'hFF);
        chk("sat_locked", locked, 1);
        strobe(~m_exp, 1'b1);
        chk("clr_with_err", err_count, 1);
        @(negedge clk); #1 clr_cnt = 1;
        @(negedge clk); #1 clr_cnt = 0;
        chk("clr_alone", err_count, 0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
